// File: rtl/nnrv_regfile.sv
// Integer register file with a pending-write scoreboard, write-back bypass and
// one-cycle registered dual read port. x0 is hardwired to zero.
module nnrv_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_reg_w_en,
    input  logic [4:0]      i_reg_w,
    input  logic [XLEN-1:0] i_reg_w_reg,
    input  logic            i_issue_en,
    input  logic [4:0]      i_issue_rd,
    input  logic            i_rd_vld,
    output logic            o_rd_rdy,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    output logic            o_rs_vld,
    output logic [XLEN-1:0] o_rs1_reg,
    output logic [XLEN-1:0] o_rs2_reg,
    output logic [31:0]     o_busy
);

    logic [XLEN-1:0] regs [NREG];
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;
    logic [31:0]     wb_mask;
    logic [31:0]     iss_mask;
    logic [31:0]     eff_busy;
    logic            accept;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs_vld_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;

    always_comb begin
        wb_mask  = i_reg_w_en ? (32'b1 << i_reg_w) : 32'b0;
        iss_mask = (i_issue_en && (i_issue_rd != 5'd0)) ? (32'b1 << i_issue_rd) : 32'b0;
        // Clear first, then set: a same-edge issue to the same index wins.
        busy_d   = ((busy_q & ~wb_mask) | iss_mask) & ~32'b1;
        // A write-back landing this cycle already resolves the hazard.
        eff_busy = busy_q & ~wb_mask;
    end

    always_comb begin
        o_rd_rdy = 1'b1;
        if ((i_rs1 != 5'd0) && eff_busy[i_rs1]) o_rd_rdy = 1'b0;
        if ((i_rs2 != 5'd0) && eff_busy[i_rs2]) o_rd_rdy = 1'b0;
        accept = i_rd_vld && o_rd_rdy;
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (i_rs1 != 5'd0) begin
            if (i_reg_w_en && (i_reg_w == i_rs1)) rs1_data = i_reg_w_reg;
            else                                  rs1_data = regs[i_rs1];
        end
        if (i_rs2 != 5'd0) begin
            if (i_reg_w_en && (i_reg_w == i_rs2)) rs2_data = i_reg_w_reg;
            else                                  rs2_data = regs[i_rs2];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (i_reg_w_en && (i_reg_w != 5'd0)) begin
            regs[i_reg_w] <= i_reg_w_reg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            busy_q   <= '0;
            rs_vld_q <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            rs_vld_q <= accept;
            if (accept) begin
                rs1_q <= rs1_data;
                rs2_q <= rs2_data;
            end
        end
    end

    assign o_busy    = busy_q;
    assign o_rs_vld  = rs_vld_q;
    assign o_rs1_reg = rs1_q;
    assign o_rs2_reg = rs2_q;

endmodule

// File: tb/tb_nnrv_regfile.sv
// Self-checking bench for nnrv_regfile: directed scenarios with literal
// expectations, then randomized traffic compared against an array-based model.
module tb_nnrv_regfile;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_reg_w_en;
    logic [4:0]      i_reg_w;
    logic [XLEN-1:0] i_reg_w_reg;
    logic            i_issue_en;
    logic [4:0]      i_issue_rd;
    logic            i_rd_vld;
    logic            o_rd_rdy;
    logic [4:0]      i_rs1;
    logic [4:0]      i_rs2;
    logic            o_rs_vld;
    logic [XLEN-1:0] o_rs1_reg;
    logic [XLEN-1:0] o_rs2_reg;
    logic [31:0]     o_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    nnrv_regfile #(.XLEN(XLEN)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_reg_w_en  (i_reg_w_en),
        .i_reg_w     (i_reg_w),
        .i_reg_w_reg (i_reg_w_reg),
        .i_issue_en  (i_issue_en),
        .i_issue_rd  (i_issue_rd),
        .i_rd_vld    (i_rd_vld),
        .o_rd_rdy    (o_rd_rdy),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .o_rs_vld    (o_rs_vld),
        .o_rs1_reg   (o_rs1_reg),
        .o_rs2_reg   (o_rs2_reg),
        .o_busy      (o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_vld;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_stalled;
    logic        m_acc;

    function automatic logic m_eff(input logic [4:0] r);
        return m_busy[r] && !(i_reg_w_en && (i_reg_w == r));
    endfunction

    function automatic logic m_rdy();
        return !(((i_rs1 != 0) && m_eff(i_rs1)) || ((i_rs2 != 0) && m_eff(i_rs2)));
    endfunction

    function automatic logic [31:0] m_val(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (i_reg_w_en && (i_reg_w == r)) return i_reg_w_reg;
        return m_regs[r];
    endfunction

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_busy = 32'h0; m_vld = 1'b0; m_rs1 = 32'h0; m_rs2 = 32'h0; m_stalled = 1'b0;
        end else begin
            m_acc     = i_rd_vld && m_rdy();
            m_stalled = i_rd_vld && !m_acc;
            m_vld     = m_acc;
            if (m_acc) begin
                m_rs1 = m_val(i_rs1);
                m_rs2 = m_val(i_rs2);
            end
            if (i_reg_w_en && (i_reg_w != 0)) m_regs[i_reg_w] = i_reg_w_reg;
            if (i_reg_w_en) m_busy[i_reg_w] = 1'b0;
            if (i_issue_en && (i_issue_rd != 0)) m_busy[i_issue_rd] = 1'b1;
        end
    end

    always @(negedge i_clk) begin
        chk("model_busy",   o_busy,    m_busy);
        chk("model_rs_vld", {31'b0, o_rs_vld}, {31'b0, m_vld});
        chk("model_rs1",    o_rs1_reg, m_rs1);
        chk("model_rs2",    o_rs2_reg, m_rs2);
        chk("model_rd_rdy", {31'b0, o_rd_rdy}, {31'b0, m_rdy()});
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_reg_w_en = 0; i_reg_w = 0; i_reg_w_reg = 0;
        i_issue_en = 0; i_issue_rd = 0;
        i_rd_vld = 0; i_rs1 = 0; i_rs2 = 0;
    endtask

    initial begin
        i_rst = 1'b0;
        idle();
        tick(); tick();
        chk("reset_busy", o_busy, 32'h0);
        chk("reset_vld", {31'b0, o_rs_vld}, 32'h0);
        chk("reset_rs1", o_rs1_reg, 32'h0);
        i_rst = 1'b1;

        // Write x5 then read it with x0.
        i_reg_w_en = 1; i_reg_w = 5; i_reg_w_reg = 32'hDEADBEEF;
        tick(); idle();
        i_rd_vld = 1; i_rs1 = 5; i_rs2 = 0;
        tick(); idle();
        chk("x5_vld", {31'b0, o_rs_vld}, 32'h1);
        chk("x5_rs1", o_rs1_reg, 32'hDEADBEEF);
        chk("x5_rs2", o_rs2_reg, 32'h0);
        tick();
        chk("vld_drops", {31'b0, o_rs_vld}, 32'h0);

        // x0 writes and issues are discarded.
        i_reg_w_en = 1; i_reg_w = 0; i_reg_w_reg = 32'h12345678;
        i_issue_en = 1; i_issue_rd = 0;
        tick(); idle();
        i_rd_vld = 1; i_rs1 = 0; i_rs2 = 5;
        tick(); idle();
        chk("x0_rs1", o_rs1_reg, 32'h0);
        chk("x0_busy", {31'b0, o_busy[0]}, 32'h0);

        // Hazard on x7 resolved by write-back with bypass.
        i_issue_en = 1; i_issue_rd = 7;
        tick(); idle();
        chk("x7_busy_set", {31'b0, o_busy[7]}, 32'h1);
        i_rd_vld = 1; i_rs1 = 0; i_rs2 = 7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("x7_stall", {31'b0, o_rd_rdy}, 32'h0);
            tick();
            chk("x7_no_vld", {31'b0, o_rs_vld}, 32'h0);
        end
        i_reg_w_en = 1; i_reg_w = 7; i_reg_w_reg = 32'hA5A5A5A5;
        #1;
        chk("x7_rdy_wb", {31'b0, o_rd_rdy}, 32'h1);
        tick(); idle();
        chk("x7_vld", {31'b0, o_rs_vld}, 32'h1);
        chk("x7_rs2", o_rs2_reg, 32'hA5A5A5A5);
        chk("x7_busy_clr", {31'b0, o_busy[7]}, 32'h0);

        // Same-edge issue and write-back of x3: issue wins.
        i_issue_en = 1; i_issue_rd = 3;
        i_reg_w_en = 1; i_reg_w = 3; i_reg_w_reg = 32'h11;
        tick(); idle();
        chk("x3_busy_kept", {31'b0, o_busy[3]}, 32'h1);
        i_reg_w_en = 1; i_reg_w = 3; i_reg_w_reg = 32'h11;
        tick(); idle();
        chk("x3_busy_clr", {31'b0, o_busy[3]}, 32'h0);
        i_rd_vld = 1; i_rs1 = 3;
        tick(); idle();
        chk("x3_rs1", o_rs1_reg, 32'h11);

        // Three back-to-back reads.
        i_reg_w_en = 1; i_reg_w = 1; i_reg_w_reg = 32'h101; tick();
        i_reg_w = 2; i_reg_w_reg = 32'h202; tick();
        i_reg_w = 3; i_reg_w_reg = 32'h303; tick(); idle();
        i_rd_vld = 1; i_rs1 = 1; tick();
        i_rs1 = 2;
        chk("b2b_vld1", {31'b0, o_rs_vld}, 32'h1);
        chk("b2b_d1", o_rs1_reg, 32'h101);
        tick();
        i_rs1 = 3;
        chk("b2b_vld2", {31'b0, o_rs_vld}, 32'h1);
        chk("b2b_d2", o_rs1_reg, 32'h202);
        tick(); idle();
        chk("b2b_vld3", {31'b0, o_rs_vld}, 32'h1);
        chk("b2b_d3", o_rs1_reg, 32'h303);

        // Reset in the middle of a stall on x9.
        i_issue_en = 1; i_issue_rd = 9;
        tick(); idle();
        i_rd_vld = 1; i_rs1 = 9;
        tick();
        chk("x9_stall", {31'b0, o_rd_rdy}, 32'h0);
        #2;
        i_rst = 1'b0;
        #1;
        chk("rst_busy", o_busy, 32'h0);
        chk("rst_vld", {31'b0, o_rs_vld}, 32'h0);
        chk("rst_rs1", o_rs1_reg, 32'h0);
        tick(); idle();
        i_rst = 1'b1;
        i_rd_vld = 1; i_rs1 = 1; i_rs2 = 5;
        tick(); idle();
        chk("post_rst_vld", {31'b0, o_rs_vld}, 32'h1);
        chk("post_rst_x1", o_rs1_reg, 32'h0);
        chk("post_rst_x5", o_rs2_reg, 32'h0);

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            i_reg_w_en  = ($urandom_range(0, 9) < 4);
            i_reg_w     = 5'($urandom_range(0, 7));
            i_reg_w_reg = $urandom;
            i_issue_en  = ($urandom_range(0, 9) < 3);
            i_issue_rd  = 5'($urandom_range(0, 7));
            if (!m_stalled) begin
                i_rd_vld = ($urandom_range(0, 9) < 6);
                i_rs1    = 5'($urandom_range(0, 7));
                i_rs2    = 5'($urandom_range(0, 7));
            end
            if (c == 1500) begin
                #3 i_rst = 1'b0;
                tick();
                i_rst = 1'b1;
                idle();
            end
            tick();
        end
        idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
